// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: memory-controller request/response, queue push, and redirect.
// master = fetch unit side, slave = memory controller / queue / branch unit side.
interface ifetch_if;
    localparam int unsigned XLEN = 32;

    logic            iq_full;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_done;
    logic [XLEN-1:0] mem_data;
    logic            inst_rdy;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc_out;

    modport master (
        input  iq_full, redirect, redirect_pc, mem_done, mem_data,
        output mem_req, mem_addr, inst_rdy, inst, pc_out
    );

    modport slave (
        output iq_full, redirect, redirect_pc, mem_done, mem_data,
        input  mem_req, mem_addr, inst_rdy, inst, pc_out
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding word request, pushes each fetched word with its PC
// into the instruction queue, predicts JAL targets statically and honours redirects.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    ifetch_if.master bus
);
    localparam int unsigned XLEN    = 32;
    localparam logic [6:0]  OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            inst_rdy_q, inst_rdy_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] jal_imm;
    logic [XLEN-1:0] next_pc;

    // Static prediction: JAL jumps to its target, everything else falls through.
    always_comb begin
        jal_imm = {{(XLEN-21){bus.mem_data[31]}}, bus.mem_data[31], bus.mem_data[19:12],
                   bus.mem_data[20], bus.mem_data[30:21], 1'b0};
        if (bus.mem_data[6:0] == OPC_JAL) next_pc = pc_q + jal_imm;
        else                              next_pc = pc_q + XLEN'(4);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        inst_rdy_d = inst_rdy_q;
        inst_d     = inst_q;
        pc_out_d   = pc_out_q;

        if (rdy) begin
            inst_rdy_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.redirect) begin
                        pc_d = bus.redirect_pc;
                    end else if (!bus.iq_full) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    // A redirect on the completion edge wins: the returned word is dropped.
                    if (bus.mem_done) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                        if (bus.redirect) begin
                            pc_d = bus.redirect_pc;
                        end else begin
                            inst_d     = bus.mem_data;
                            pc_out_d   = pc_q;
                            inst_rdy_d = 1'b1;
                            pc_d       = next_pc;
                        end
                    end else if (bus.redirect) begin
                        pc_d    = bus.redirect_pc;
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (bus.redirect) pc_d = bus.redirect_pc;
                    if (bus.mem_done) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            inst_rdy_q <= 1'b0;
            inst_q     <= '0;
            pc_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inst_rdy_q <= inst_rdy_d;
            inst_q     <= inst_d;
            pc_out_q   <= pc_out_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.inst_rdy = inst_rdy_q;
    assign bus.inst     = inst_q;
    assign bus.pc_out   = pc_out_q;
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly upstream of the instruction queue. Holds the architectural fetch PC and issues one word request at a time to the memory controller. Each returned instruction is pushed into the queue with its PC as a one-cycle `inst_rdy` pulse. Handles queue backpressure, static JAL target prediction and redirects from branch resolution, including discarding in-flight fetches.

## Interface

- RESET_PC, 32'h0000_0000, fetch PC after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = all state holds
- iq_full  in  1  instruction queue cannot accept (queue guarantees ≥2 free slots when low)
- redirect  in  1  one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  in  32  new fetch PC
- mem_req  out  1  fetch request to memory controller; held until mem_done
- mem_addr  out  32  word address of request; stable while mem_req high
- mem_done  in  1  one-cycle pulse: mem_data valid this cycle
- mem_data  in  32  returned instruction word
- inst_rdy  out  1  one-cycle push pulse to instruction queue
- inst  out  32  fetched instruction, valid when inst_rdy
- pc_out  out  32  PC of inst, valid when inst_rdy

## Operation

- Reset values: pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=0, inst_rdy=0, inst=0, pc_out=0.
- rdy low: no register changes; mem_done/redirect during that cycle are not sampled; memory controller shares rdy.
- At most one request outstanding.
- States:
  - IDLE: redirect → pc<=redirect_pc, stay IDLE. Else if !iq_full → mem_req<=1, mem_addr<=pc, go WAIT. Else stay IDLE.
  - WAIT:
    - mem_done && !redirect → inst<=mem_data, pc_out<=pc, inst_rdy<=1, pc<=next_pc(mem_data), mem_req<=0, go IDLE.
    - mem_done && redirect → data discarded, pc<=redirect_pc, mem_req<=0, go IDLE, no push.
    - redirect && !mem_done → pc<=redirect_pc, go DROP; mem_req and mem_addr unchanged.
  - DROP: waits out the stale request. A redirect here updates pc only. On mem_done: mem_req<=0, data discarded, go IDLE.
- inst_rdy is 1 only in the cycle after an accepted mem_done; otherwise 0.
- next_pc:
  - opcode mem_data[6:0]==7'b1101111 (JAL): pc + sext({mem_data[31], mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0}).
  - Else pc+4.
  - 32-bit modulo arithmetic; wrap past 32'hFFFF_FFFC to 0 is silent.
- Branches and JALR are predicted not-taken (pc+4). Mispredicts arrive as redirect.
- iq_full is sampled only in IDLE. A request already in flight completes and pushes even if iq_full rises; the queue's slack absorbs it.

## Timing

- Request issue: in IDLE with !iq_full at edge N, mem_req=1 from cycle N+1.
- Fetch latency: mem_done sampled at edge M → inst_rdy/inst/pc_out valid in cycle M+1. Back-to-back: next mem_req earliest at M+2, giving ≥1 idle cycle between requests.
- Redirect priority over the pending fetch result: same-edge redirect and mem_done → no push.
- After redirect in IDLE at edge R, first request with mem_addr=redirect_pc asserts at R+2 if !iq_full.
- Reset mid-fetch: mem_req drops next cycle; any later mem_done from the old request arrives in IDLE and must be ignored (no push).

## Test plan

- Sequential fetch: reset, memory returns 32'h00000013 after 2 cycles each → pushes at pc_out 0, 4, 8; inst_rdy exactly one cycle each; mem_addr matches.
- JAL prediction: word at 0x10 = 32'h0100006F (jal x0,+16) → push pc_out=0x10, next mem_addr=0x20. Negative case 32'hFF1FF06F at 0x20 → next mem_addr=0x10.
- Backpressure: hold iq_full=1 in IDLE for 5 cycles → mem_req stays 0. Release → request at the held PC, no PC skipped.
- Redirect while WAIT: request 0x8 outstanding, redirect_pc=0x100 → stale mem_done produces no push, next mem_addr=0x100. Repeat with redirect on the same cycle as mem_done → no push, next request 0x100.
- rdy stall: drop rdy for 3 cycles mid-WAIT (memory also stalled) → all outputs frozen, fetch completes normally after.
- Reset mid-fetch: assert rst during WAIT at pc 0x40 → all outputs reset. A late mem_done is ignored; next request at RESET_PC.
